// File: rtl/router_fifo.sv
// Per-port output FIFO of the router. It stores each byte together with its header
// flag and tracks how many bytes of the current packet are still unread.
module router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_reset,
    input  logic             wr_en,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             pkt_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH:0] mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [6:0]     pkt_cnt;
    logic [WIDTH:0] rd_entry;
    logic           do_wr;
    logic           do_rd;

    // The extra MSB on each pointer separates a full FIFO from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // Both strobes are qualified by start-of-cycle state, so a simultaneous
    // read at full cannot make room for the write in the same cycle.
    assign do_wr = wr_en && !full && !soft_reset;
    assign do_rd = rd_en && !empty && !soft_reset;

    assign rd_entry = mem[rd_ptr[AW-1:0]];
    assign pkt_busy = (pkt_cnt != 7'd0);

    // Memory is not cleared by either reset; the pointers alone decide validity.
    always_ff @(posedge clk) begin
        if (rst && do_wr) begin
            mem[wr_ptr[AW-1:0]] <= {lfd_state, din};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || soft_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pkt_cnt <= 7'd0;
            dout    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                dout   <= rd_entry[WIDTH-1:0];
                // A header reload discards whatever was left of an aborted packet.
                if (rd_entry[WIDTH]) begin
                    pkt_cnt <= {1'b0, rd_entry[7:2]} + 7'd1;
                end else if (pkt_cnt != 7'd0) begin
                    pkt_cnt <= pkt_cnt - 7'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: fill/drain, packet counting, simultaneous
// read/write at the boundaries, soft flush and pointer wrap-around.
module tb_router_fifo;

    logic       clk;
    logic       rst;
    logic       soft_reset;
    logic       wr_en;
    logic       lfd_state;
    logic [7:0] din;
    logic       rd_en;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       pkt_busy;

    int checks;
    int errors;

    router_fifo #(.WIDTH(8), .DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .soft_reset (soft_reset),
        .wr_en      (wr_en),
        .lfd_state  (lfd_state),
        .din        (din),
        .rd_en      (rd_en),
        .dout       (dout),
        .full       (full),
        .empty      (empty),
        .pkt_busy   (pkt_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one clock cycle of strobes; outputs are sampled 1ns after the edge.
    task automatic applyStimulus(input logic w, input logic r, input logic h,
                                 input logic [7:0] d);
        wr_en     = w;
        rd_en     = r;
        lfd_state = h;
        din       = d;
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        lfd_state = 1'b0;
    endtask

    task automatic hardReset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int n;
        int k;
        int w;
        int rd_idx;
        logic [7:0] v;

        checks     = 0;
        errors     = 0;
        soft_reset = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        lfd_state  = 1'b0;
        din        = 8'h00;

        hardReset();
        checkOutput("reset_empty", 32'(empty), 32'd1);
        checkOutput("reset_full", 32'(full), 32'd0);
        checkOutput("reset_busy", 32'(pkt_busy), 32'd0);
        checkOutput("reset_dout", 32'(dout), 32'h00);

        // Fill to capacity, try one extra write, then drain in order.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'(i));
            checkOutput("fill_full", 32'(full), (i == 16) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hAA);
        checkOutput("overflow_full", 32'(full), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
            checkOutput("drain_dout", 32'(dout), 32'(i));
            checkOutput("drain_cnt", 32'(dut.pkt_cnt), 32'd0);
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("underflow_dout", 32'(dout), 32'h10);
        checkOutput("underflow_empty", 32'(empty), 32'd1);

        // Header 0x0D announces 3 payload bytes plus parity: count of 4.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h0D);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h11 + i));
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("hdr_dout", 32'(dout), 32'h0D);
        checkOutput("hdr_cnt", 32'(dut.pkt_cnt), 32'd4);
        checkOutput("hdr_busy", 32'(pkt_busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
            checkOutput("pay_dout", 32'(dout), 32'(8'h11 + i));
            checkOutput("pay_cnt", 32'(dut.pkt_cnt), 32'(3 - i));
        end
        checkOutput("pay_busy", 32'(pkt_busy), 32'd0);

        // Full FIFO with both strobes: only the read happens.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        checkOutput("both_full_pre", 32'(full), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h99);
        checkOutput("both_full_dout", 32'(dout), 32'h20);
        checkOutput("both_full_full", 32'(full), 32'd0);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
            checkOutput("both_full_rest", 32'(dout), 32'(8'h20 + i));
        end
        checkOutput("both_full_empty", 32'(empty), 32'd1);

        // Empty FIFO with both strobes: only the write happens.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h55);
        checkOutput("both_empty_dout", 32'(dout), 32'h2F);
        checkOutput("both_empty_empty", 32'(empty), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("both_empty_read", 32'(dout), 32'h55);
        checkOutput("both_empty_after", 32'(empty), 32'd1);

        // Partially filled with both strobes: occupancy unchanged.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h61);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h62);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h63);
        checkOutput("both_mid_dout", 32'(dout), 32'h61);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("both_mid_r1", 32'(dout), 32'h62);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("both_mid_r2", 32'(dout), 32'h63);
        checkOutput("both_mid_empty", 32'(empty), 32'd1);

        // A second header mid-packet reloads the count (0x05 -> 1+1 = 2).
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h0D);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h71);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h05);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h72);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("abort_cnt_a", 32'(dut.pkt_cnt), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("abort_dout", 32'(dout), 32'h05);
        checkOutput("abort_cnt_b", 32'(dut.pkt_cnt), 32'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("abort_cnt_c", 32'(dut.pkt_cnt), 32'd1);
        checkOutput("abort_busy", 32'(pkt_busy), 32'd1);

        // Soft flush in the middle of a packet; the concurrent write is ignored.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h0D);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h81 + i));
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("flush_pre_cnt", 32'(dut.pkt_cnt), 32'd2);
        checkOutput("flush_pre_dout", 32'(dout), 32'h82);
        soft_reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h77);
        soft_reset = 1'b0;
        checkOutput("flush_empty", 32'(empty), 32'd1);
        checkOutput("flush_busy", 32'(pkt_busy), 32'd0);
        checkOutput("flush_dout", 32'(dout), 32'h00);

        // 40 write/read pairs in bursts of 1..5 so both pointers wrap twice.
        hardReset();
        n = 0;
        rd_idx = 0;
        k = 1;
        while (n < 40) begin
            w = (40 - n < k) ? (40 - n) : k;
            for (int i = 0; i < w; i++) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h80 + n + i));
                checkOutput("wrap_full", 32'(full), 32'd0);
            end
            n = n + w;
            for (int i = 0; i < w; i++) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
                v = 8'(8'h80 + rd_idx);
                checkOutput("wrap_dout", 32'(dout), 32'(v));
                rd_idx++;
            end
            checkOutput("wrap_empty", 32'(empty), 32'd1);
            k = (k % 5) + 1;
        end
        checkOutput("wrap_wrptr", 32'(dut.wr_ptr), 32'd8);
        checkOutput("wrap_rdptr", 32'(dut.rd_ptr), 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
